sha_hash_state_bank: RTL and testbench
======================================

Name: sha_hash_state_bank

Overview:
- Parametrised hash-state register bank for the SHA-2 datapath.
- Holds all NUM_WORDS chaining words (H0..H7 for SHA-256) in one block.
- Loads a selectable initial vector (SHA-256 or SHA-224).
- After each compression round, adds the working variables a..h into the state in a sequenced pass, with a valid/ready handshake and a block counter.
- Sits between the compression core and the digest/output logic.

Parameters:
- WORD_W, 32: width of each state word.
- NUM_WORDS, 8: number of chaining words.
- ADDS_PER_CYCLE, 1: words accumulated per clock. Must divide NUM_WORDS.
- CNT_W, 16: width of the block counter.
- IV_A, SHA-256 IV packed (word0 = 6a09e667 in LSBs … word7 = 5be0cd19): IV when mode_alt=0.
- IV_B, SHA-224 IV packed (word0 = c1059ed8 … word7 = befa4fa4): IV when mode_alt=1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- init_req  in  1  pulse: load IV selected by mode_alt, clear block_cnt.
- mode_alt  in  1  IV select; sampled only when init_req is high.
- acc_valid  in  1  compression result available.
- acc_ready  out  1  bank can accept acc_words.
- acc_words  in  NUM_WORDS*WORD_W  working variables a..h; a in the LSBs.
- busy  out  1  accumulation pass in progress.
- acc_done  out  1  one-cycle pulse when a pass completes.
- h_out  out  NUM_WORDS*WORD_W  current chaining state; word0 in the LSBs.
- block_cnt  out  CNT_W  number of completed passes since the last init.
- cnt_sat  out  1  high when block_cnt is all ones.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - h_out = IV_A, block_cnt = 0.
  - State IDLE, idx = 0.
  - acc_done = 0, busy = 0.
  - acc_ready is forced 0 while rst_n is low.
- acc_ready = rst_n && (state==IDLE) && !init_req. This is combinational; no dependence on acc_valid.
- FSM states: IDLE and ACCUM.
- IDLE:
  - init_req=1: h_out <= (mode_alt ? IV_B : IV_A), block_cnt <= 0, stay IDLE. init_req has priority over acc_valid, and no handshake occurs that cycle.
  - Otherwise acc_valid && acc_ready: capture acc_words into an internal holding register, idx <= 0, go to ACCUM.
- ACCUM:
  - Each cycle, for k in 0..ADDS_PER_CYCLE-1: H[idx+k] <= H[idx+k] + hold[idx+k], modulo 2^WORD_W. No carry crosses between words.
  - Then idx <= idx + ADDS_PER_CYCLE.
  - On the group containing word NUM_WORDS-1:
    - return to IDLE;
    - acc_done = 1 on the following cycle;
    - block_cnt increments, saturating at 2^CNT_W-1. No wrap; cnt_sat stays high.
- Latency: NUM_WORDS/ADDS_PER_CYCLE cycles from handshake to the final write. acc_done is registered, high in the cycle after the final write. The earliest next handshake is that same cycle.
- busy = (state==ACCUM).
- h_out is a direct register view. Words update progressively during ACCUM. Consumers read only after acc_done.
- init_req during ACCUM aborts the pass:
  - IV is loaded and block_cnt is cleared;
  - state goes to IDLE;
  - no acc_done pulse and no increment.
- rst_n low mid-pass behaves the same as reset: no acc_done.
- acc_words is not required stable after the handshake.

Decomposition:
- Shared package sha_state_pkg:
  - SHA256_IV and SHA224_IV packed constants;
  - WORD_W / NUM_WORDS defaults;
  - state enum {IDLE, ACCUM}.
- One sub-module, sha_word_adder: ADDS_PER_CYCLE parallel WORD_W modular adders, instantiated once. The FSM, idx counter, holding register and block counter stay in the top.

Test Plan:
- Reset → h_out word5 = 9b05688c, word0 = 6a09e667, block_cnt = 0. acc_ready=1 one cycle after rst_n rises.
- IDLE, acc_words all words = 00000001, acc_valid pulse (ADDS_PER_CYCLE=1):
  - busy for 8 cycles;
  - acc_done 9 cycles after the handshake;
  - word5 = 9b05688d, word0 = 6a09e668, block_cnt = 1.
- Wrap: word7 = 5be0cd19, acc word7 = a41f32e7 → word7 = 00000000. word6 is unaffected by carry.
- init_req with mode_alt=1 → word0 = c1059ed8, word7 = befa4fa4, block_cnt = 0. init_req and acc_valid in the same IDLE cycle → acc_ready=0, no pass starts.
- init_req at cycle 3 of ACCUM → IV_A restored in all words, no acc_done, block_cnt = 0, acc_ready=1 the next cycle.
- CNT_W=2, ADDS_PER_CYCLE=8:
  - each pass takes 1 cycle and acc_done follows the next cycle;
  - after 3 passes block_cnt = 3 and cnt_sat = 1;
  - a 4th pass keeps block_cnt = 3 and still pulses acc_done.

Source files
------------

// File: rtl/sha_state_pkg.sv
// rtl/sha_state_pkg.sv - shared constants and FSM state type for the SHA-2 hash-state bank
package sha_state_pkg;

    localparam int WORD_W_DEF    = 32;
    localparam int NUM_WORDS_DEF = 8;

    // Word 0 sits in the least significant bits.
    localparam logic [255:0] SHA256_IV = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };

    localparam logic [255:0] SHA224_IV = {
        32'hbefa4fa4, 32'h64f98fa7, 32'h68581511, 32'hffc00b31,
        32'hf70e5939, 32'h3070dd17, 32'h367cd507, 32'hc1059ed8
    };

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

endpackage

// File: rtl/sha_hash_state_bank_if.sv
// rtl/sha_hash_state_bank_if.sv - accumulate channel (valid/ready + working variables a..h)
// master drives acc_valid/acc_words and observes acc_ready; slave is the state bank.
interface sha_hash_state_bank_if #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 8
);
    logic                          acc_valid;
    logic                          acc_ready;
    logic [NUM_WORDS*WORD_W-1:0]   acc_words;

    modport master (
        output acc_valid,
        output acc_words,
        input  acc_ready
    );

    modport slave (
        input  acc_valid,
        input  acc_words,
        output acc_ready
    );
endinterface

// File: rtl/sha_word_adder.sv
// rtl/sha_word_adder.sv - N independent WORD_W-bit modular adders
// Ports: a, b  : N packed words (word 0 in LSBs)
//        sum   : per-word a+b mod 2^WORD_W; carries never cross word boundaries
module sha_word_adder #(
    parameter int WORD_W = 32,
    parameter int N      = 1
) (
    input  logic [N*WORD_W-1:0] a,
    input  logic [N*WORD_W-1:0] b,
    output logic [N*WORD_W-1:0] sum
);

    always_comb begin
        sum = '0;
        for (int k = 0; k < N; k++) begin
            sum[k*WORD_W +: WORD_W] = a[k*WORD_W +: WORD_W] + b[k*WORD_W +: WORD_W];
        end
    end

endmodule

// File: rtl/sha_hash_state_bank.sv
// rtl/sha_hash_state_bank.sv - SHA-2 chaining-state bank with IV load and sequenced accumulate
// Ports: clk, rst_n (sync, active-low)
//        init_req/mode_alt : load IV_A (mode_alt=0) or IV_B (mode_alt=1), clear block_cnt
//        acc (slave)       : acc_valid/acc_ready/acc_words handshake for working variables a..h
//        busy              : accumulation pass in progress
//        acc_done          : one-cycle pulse after the final word write of a pass
//        h_out             : live chaining state, word 0 in LSBs
//        block_cnt/cnt_sat : saturating count of completed passes since init
module sha_hash_state_bank
    import sha_state_pkg::*;
#(
    parameter int                          WORD_W         = WORD_W_DEF,
    parameter int                          NUM_WORDS      = NUM_WORDS_DEF,
    parameter int                          ADDS_PER_CYCLE = 1,
    parameter int                          CNT_W          = 16,
    parameter logic [NUM_WORDS*WORD_W-1:0] IV_A           = SHA256_IV,
    parameter logic [NUM_WORDS*WORD_W-1:0] IV_B           = SHA224_IV
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         init_req,
    input  logic                         mode_alt,
    sha_hash_state_bank_if.slave         acc,
    output logic                         busy,
    output logic                         acc_done,
    output logic [NUM_WORDS*WORD_W-1:0]  h_out,
    output logic [CNT_W-1:0]             block_cnt,
    output logic                         cnt_sat
);

    // The pass walks the state in groups of ADDS_PER_CYCLE words; grp_q is the
    // group index, so the word index is grp_q * ADDS_PER_CYCLE.
    localparam int NUM_GROUPS = NUM_WORDS / ADDS_PER_CYCLE;
    localparam int GRP_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam int GRP_BITS   = ADDS_PER_CYCLE * WORD_W;
    localparam int STATE_BITS = NUM_WORDS * WORD_W;

    state_e                 state_q, state_d;
    logic [GRP_W-1:0]       grp_q, grp_d;
    logic [STATE_BITS-1:0]  h_q, h_d;
    logic [STATE_BITS-1:0]  hold_q, hold_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   done_q, done_d;

    int                     base;
    logic                   last_grp;
    logic [GRP_BITS-1:0]    add_a;
    logic [GRP_BITS-1:0]    add_b;
    logic [GRP_BITS-1:0]    add_sum;
    logic                   ready;

    assign base     = int'(grp_q) * GRP_BITS;
    assign last_grp = (grp_q == GRP_W'(NUM_GROUPS - 1));

    // init_req blocks the handshake so an IV load and a pass never start together.
    assign ready = rst_n && (state_q == IDLE) && !init_req;

    always_comb begin
        add_a = h_q[base +: GRP_BITS];
        add_b = hold_q[base +: GRP_BITS];
    end

    sha_word_adder #(
        .WORD_W (WORD_W),
        .N      (ADDS_PER_CYCLE)
    ) u_adder (
        .a   (add_a),
        .b   (add_b),
        .sum (add_sum)
    );

    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        h_d     = h_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        if (init_req) begin
            // Also aborts an in-flight pass: no done pulse, no count.
            h_d     = mode_alt ? IV_B : IV_A;
            cnt_d   = '0;
            state_d = IDLE;
            grp_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (acc.acc_valid && ready) begin
                        // Snapshot so the producer may change acc_words immediately.
                        hold_d  = acc.acc_words;
                        grp_d   = '0;
                        state_d = ACCUM;
                    end
                end
                ACCUM: begin
                    h_d[base +: GRP_BITS] = add_sum;
                    if (last_grp) begin
                        state_d = IDLE;
                        grp_d   = '0;
                        done_d  = 1'b1;
                        if (cnt_q != {CNT_W{1'b1}}) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        grp_d = grp_q + GRP_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    grp_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grp_q   <= '0;
            h_q     <= IV_A;
            hold_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grp_q   <= grp_d;
            h_q     <= h_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign acc.acc_ready = ready;
    assign busy          = (state_q == ACCUM);
    assign acc_done      = done_q;
    assign h_out         = h_q;
    assign block_cnt     = cnt_q;
    assign cnt_sat       = &cnt_q;

endmodule

// File: tb/tb_sha_hash_state_bank.sv
// tb/tb_sha_hash_state_bank.sv - self-checking bench for sha_hash_state_bank
module tb_sha_hash_state_bank;

    localparam logic [255:0] IV256 = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };
    localparam logic [255:0] IV224 = {
        32'hbefa4fa4, 32'h64f98fa7, 32'h68581511, 32'hffc00b31,
        32'hf70e5939, 32'h3070dd17, 32'h367cd507, 32'hc1059ed8
    };

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n = 1'b0;
    logic         init0 = 1'b0, mode0 = 1'b0;
    logic         init1 = 1'b0, mode1 = 1'b0;
    logic         busy0, done0, sat0;
    logic         busy1, done1, sat1;
    logic [255:0] h0, h1;
    logic [15:0]  bc0;
    logic [1:0]   bc1;

    sha_hash_state_bank_if #(.WORD_W(32), .NUM_WORDS(8)) if0 ();
    sha_hash_state_bank_if #(.WORD_W(32), .NUM_WORDS(8)) if1 ();

    sha_hash_state_bank #(.ADDS_PER_CYCLE(1), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .init_req(init0), .mode_alt(mode0), .acc(if0),
        .busy(busy0), .acc_done(done0), .h_out(h0), .block_cnt(bc0), .cnt_sat(sat0)
    );

    sha_hash_state_bank #(.ADDS_PER_CYCLE(8), .CNT_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .init_req(init1), .mode_alt(mode1), .acc(if1),
        .busy(busy1), .acc_done(done1), .h_out(h1), .block_cnt(bc1), .cnt_sat(sat1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: eight plain words and a saturating counter per DUT.
    logic [31:0] hm [2][8];
    int          mcnt [2];
    int          mmax [2];
    int          ngrp [2];

    typedef struct {
        bit           do_init;
        bit           mode;
        logic [255:0] w;
        int           ia;
        logic [31:0]  va;
        int           ib;
        logic [31:0]  vb;
        int           cnt;
    } vec_t;

    vec_t tbl [4];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] model_h(input int d);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = hm[d][i];
        return r;
    endfunction

    function automatic void model_load(input int d, input logic [255:0] v);
        for (int i = 0; i < 8; i++) hm[d][i] = v[i*32 +: 32];
        mcnt[d] = 0;
    endfunction

    function automatic logic [255:0] rand_words();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [255:0] get_h(input int d);
        return (d == 0) ? h0 : h1;
    endfunction
    function automatic int get_cnt(input int d);
        return (d == 0) ? int'(bc0) : int'(bc1);
    endfunction
    function automatic logic get_busy(input int d);
        return (d == 0) ? busy0 : busy1;
    endfunction
    function automatic logic get_done(input int d);
        return (d == 0) ? done0 : done1;
    endfunction
    function automatic logic get_ready(input int d);
        return (d == 0) ? if0.acc_ready : if1.acc_ready;
    endfunction
    function automatic logic get_sat(input int d);
        return (d == 0) ? sat0 : sat1;
    endfunction

    task automatic drive_acc(input int d, input logic v, input logic [255:0] w);
        if (d == 0) begin
            if0.acc_valid = v;
            if0.acc_words = w;
        end else begin
            if1.acc_valid = v;
            if1.acc_words = w;
        end
    endtask

    task automatic drive_init(input int d, input logic i, input logic m);
        if (d == 0) begin
            init0 = i;
            mode0 = m;
        end else begin
            init1 = i;
            mode1 = m;
        end
    endtask

    task automatic do_init(input int d, input bit m);
        @(negedge clk);
        drive_init(d, 1'b1, m);
        @(posedge clk);
        #1 drive_init(d, 1'b0, 1'b0);
        model_load(d, m ? IV224 : IV256);
        @(negedge clk);
        check("init_h", get_h(d), model_h(d));
        check("init_cnt", 256'(get_cnt(d)), 256'(0));
    endtask

    // One full pass: handshake, then watch busy/acc_done for a bounded window.
    task automatic run_pass(input int d, input logic [255:0] w);
        int busy_n, done_at, done_n;
        busy_n = 0; done_at = 0; done_n = 0;
        @(negedge clk);
        check("ready_before_pass", 256'(get_ready(d)), 256'(1));
        drive_acc(d, 1'b1, w);
        @(posedge clk);
        #1 drive_acc(d, 1'b0, rand_words());
        for (int s = 1; s <= ngrp[d] + 3; s++) begin
            @(negedge clk);
            if (get_busy(d)) busy_n++;
            if (get_done(d)) begin
                done_n++;
                if (done_at == 0) done_at = s;
            end
        end
        for (int i = 0; i < 8; i++) hm[d][i] = hm[d][i] + w[i*32 +: 32];
        if (mcnt[d] < mmax[d]) mcnt[d]++;
        check("busy_cycles", 256'(busy_n), 256'(ngrp[d]));
        check("done_latency", 256'(done_at), 256'(ngrp[d] + 1));
        check("done_pulses", 256'(done_n), 256'(1));
        check("pass_h", get_h(d), model_h(d));
        check("pass_cnt", 256'(get_cnt(d)), 256'(mcnt[d]));
        check("pass_sat", 256'(get_sat(d)), 256'(mcnt[d] == mmax[d]));
    endtask

    initial begin
        int done_n;
        int exp_cnt1 [4];

        mmax[0] = 65535; mmax[1] = 3;
        ngrp[0] = 8;     ngrp[1] = 1;
        drive_acc(0, 1'b0, '0);
        drive_acc(1, 1'b0, '0);

        tbl[0] = '{1'b1, 1'b0, {8{32'h00000001}},        5, 32'h9b05688d, 0, 32'h6a09e668, 1};
        tbl[1] = '{1'b1, 1'b0, {32'ha41f32e7, 224'h0},   7, 32'h00000000, 6, 32'h1f83d9ab, 1};
        tbl[2] = '{1'b1, 1'b1, 256'h0,                   0, 32'hc1059ed8, 7, 32'hbefa4fa4, 1};
        tbl[3] = '{1'b0, 1'b0, {224'h0, 32'h3efa6128},   0, 32'h00000000, 7, 32'hbefa4fa4, 2};
        exp_cnt1 = '{1, 2, 3, 3};

        // Reset
        repeat (3) @(negedge clk);
        check("ready_in_reset0", 256'(if0.acc_ready), 256'(0));
        check("ready_in_reset1", 256'(if1.acc_ready), 256'(0));
        rst_n = 1'b1;
        @(negedge clk);
        model_load(0, IV256);
        model_load(1, IV256);
        check("rst_word5", 256'(h0[5*32 +: 32]), 256'(32'h9b05688c));
        check("rst_word0", 256'(h0[31:0]), 256'(32'h6a09e667));
        check("rst_h", h0, IV256);
        check("rst_cnt", 256'(bc0), 256'(0));
        check("rst_ready", 256'(if0.acc_ready), 256'(1));
        check("rst_busy", 256'(busy0), 256'(0));
        check("rst_done", 256'(done0), 256'(0));
        check("rst_sat1", 256'(sat1), 256'(0));

        // Table-driven passes on the one-word-per-cycle instance
        for (int t = 0; t < 4; t++) begin
            if (tbl[t].do_init) do_init(0, tbl[t].mode);
            run_pass(0, tbl[t].w);
            check($sformatf("tbl%0d_word%0d", t, tbl[t].ia), 256'(h0[tbl[t].ia*32 +: 32]), 256'(tbl[t].va));
            check($sformatf("tbl%0d_word%0d", t, tbl[t].ib), 256'(h0[tbl[t].ib*32 +: 32]), 256'(tbl[t].vb));
            check($sformatf("tbl%0d_cnt", t), 256'(bc0), 256'(tbl[t].cnt));
        end

        // init_req and acc_valid together: init wins, no pass
        @(negedge clk);
        drive_init(0, 1'b1, 1'b1);
        drive_acc(0, 1'b1, {8{32'h11111111}});
        #1 check("ready_during_init", 256'(if0.acc_ready), 256'(0));
        @(posedge clk);
        #1 begin
            drive_init(0, 1'b0, 1'b0);
            drive_acc(0, 1'b0, '0);
        end
        model_load(0, IV224);
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check("no_pass_busy", 256'(busy0), 256'(0));
        end
        check("init_wins_h", h0, IV224);
        check("init_wins_cnt", 256'(bc0), 256'(0));

        // Abort at cycle 3 of a pass
        run_pass(0, rand_words());
        @(negedge clk);
        drive_acc(0, 1'b1, rand_words());
        @(posedge clk);
        #1 drive_acc(0, 1'b0, '0);
        repeat (3) @(negedge clk);
        check("abort_busy_mid", 256'(busy0), 256'(1));
        drive_init(0, 1'b1, 1'b0);
        @(posedge clk);
        #1 drive_init(0, 1'b0, 1'b0);
        model_load(0, IV256);
        @(negedge clk);
        check("abort_busy", 256'(busy0), 256'(0));
        check("abort_h", h0, IV256);
        check("abort_cnt", 256'(bc0), 256'(0));
        check("abort_ready", 256'(if0.acc_ready), 256'(1));
        done_n = 0;
        for (int s = 0; s < 12; s++) begin
            @(negedge clk);
            if (done0) done_n++;
        end
        check("abort_no_done", 256'(done_n), 256'(0));

        // Randomised passes with occasional re-init
        for (int r = 0; r < 20; r++) begin
            if ($urandom_range(0, 4) == 0) do_init(0, 1'($urandom_range(0, 1)));
            run_pass(0, rand_words());
        end

        // Eight-words-per-cycle instance with a 2-bit counter
        do_init(1, 1'b0);
        for (int p = 0; p < 4; p++) begin
            run_pass(1, rand_words());
            check($sformatf("sat_pass%0d_cnt", p), 256'(bc1), 256'(exp_cnt1[p]));
            check($sformatf("sat_pass%0d_flag", p), 256'(sat1), 256'(p >= 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
